// File: rtl/bldc_pkg.sv
// Shared sector codes, gate FSM encodings and the hall/gate lookup helpers.
// Latency: none; types, constants and pure functions only.
// Backpressure: none; nothing in here holds state.
package bldc_pkg;

  localparam logic [2:0] SEC_A       = 3'd0;
  localparam logic [2:0] SEC_B       = 3'd1;
  localparam logic [2:0] SEC_C       = 3'd2;
  localparam logic [2:0] SEC_D       = 3'd3;
  localparam logic [2:0] SEC_E       = 3'd4;
  localparam logic [2:0] SEC_F       = 3'd5;
  localparam logic [2:0] SEC_INVALID = 3'd7;

  typedef enum logic [1:0] {
    ST_OFF      = 2'd0,
    ST_DEADTIME = 2'd1,
    ST_DRIVE    = 2'd2,
    ST_FAULT    = 2'd3
  } gate_state_e;

  // Raw {hall1,hall2,hall3} to sector; 000 and 111 cannot occur on a healthy motor.
  function automatic logic [2:0] hall_decode(input logic [2:0] code);
    case (code)
      3'b101:  return SEC_A;
      3'b100:  return SEC_B;
      3'b110:  return SEC_C;
      3'b010:  return SEC_D;
      3'b011:  return SEC_E;
      3'b001:  return SEC_F;
      default: return SEC_INVALID;
    endcase
  endfunction

  // Returns {INHA,INHB,INHC,INLA,INLB,INLC}; high sides are later gated by pwm.
  function automatic logic [5:0] gate_pattern(input logic [2:0] sec, input logic dir);
    case ({dir, sec})
      {1'b1, SEC_A}: return 6'b001_010;
      {1'b1, SEC_B}: return 6'b100_010;
      {1'b1, SEC_C}: return 6'b100_001;
      {1'b1, SEC_D}: return 6'b010_001;
      {1'b1, SEC_E}: return 6'b010_100;
      {1'b1, SEC_F}: return 6'b001_100;
      {1'b0, SEC_A}: return 6'b010_001;
      {1'b0, SEC_B}: return 6'b010_100;
      {1'b0, SEC_C}: return 6'b001_100;
      {1'b0, SEC_D}: return 6'b001_010;
      {1'b0, SEC_E}: return 6'b100_010;
      {1'b0, SEC_F}: return 6'b100_001;
      default:       return 6'b000_000;
    endcase
  endfunction

endpackage

// File: rtl/bldc_hall_filter.sv
// Hall synchroniser plus stability filter; outputs the last accepted 3-bit code.
// Latency: 2 sync cycles + HALL_FILTER identical samples before a new code is accepted.
// Backpressure: none; free-running sampler, code_vld stays high once any code is accepted.
module hall_filter #(
  parameter int HALL_FILTER = 4
) (
  input  logic       CLK,
  input  logic       reset,
  input  logic [2:0] hall_raw,
  output logic [2:0] code,
  output logic       code_vld
);

  localparam int FW = $clog2(HALL_FILTER + 1);

  logic [2:0]    sync1_q, sync2_q;
  logic [2:0]    last_q, last_d;
  logic [2:0]    code_q, code_d;
  logic [FW-1:0] cnt_q, cnt_d;
  logic          vld_q, vld_d;

  // Count consecutive identical synchronised samples; accept once the run is long enough.
  always_comb begin
    last_d = last_q;
    cnt_d  = cnt_q;
    code_d = code_q;
    vld_d  = vld_q;
    if (cnt_q == '0 || sync2_q != last_q) begin
      last_d = sync2_q;
      cnt_d  = FW'(1);
    end else if (cnt_q != FW'(HALL_FILTER)) begin
      cnt_d = cnt_q + FW'(1);
    end
    if (cnt_d == FW'(HALL_FILTER)) begin
      code_d = last_d;
      vld_d  = 1'b1;
    end
  end

  // Two-flop synchroniser for the asynchronous hall pins, then filter state.
  always_ff @(posedge CLK) begin
    if (reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
      last_q  <= '0;
      cnt_q   <= '0;
      code_q  <= '0;
      vld_q   <= 1'b0;
    end else begin
      sync1_q <= hall_raw;
      sync2_q <= sync1_q;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      code_q  <= code_d;
      vld_q   <= vld_d;
    end
  end

  assign code     = code_q;
  assign code_vld = vld_q;

endmodule

// File: rtl/bldc_commutator.sv
// Six-step BLDC commutation: hall decode, dead time, PWM, current fold-back; BLDC_BRAKE_EN adds a brake input.
// Latency: gates react 1 cycle after a sector/dir/enable event and are driven DEADTIME_CYCLES+1 cycles later.
// Backpressure: none; inputs are sampled every cycle and all outputs are registered.
module bldc_commutator
  import bldc_pkg::*;
#(
  parameter int DUTY_W          = 24,
  parameter int CUR_W           = 16,
  parameter int PWM_PERIOD      = 1600,
  parameter int DEADTIME_CYCLES = 1024,
  parameter int HALL_FILTER     = 4,
  parameter int FOLDBACK_SHIFT  = 3
) (
  input  logic                     CLK,
  input  logic                     reset,
  input  logic                     enable,
  input  logic signed [DUTY_W-1:0] duty,
  input  logic signed [CUR_W-1:0]  current,
  input  logic signed [CUR_W-1:0]  current_limit,
  input  logic [2:0]               hall,
  input  logic                     fault_clr,
`ifdef BLDC_BRAKE_EN
  input  logic                     brake,
`endif
  output logic                     INHA,
  output logic                     INLA,
  output logic                     INHB,
  output logic                     INLB,
  output logic                     INHC,
  output logic                     INLC,
  output logic [2:0]               sector,
  output logic                     dir,
  output logic                     in_deadtime,
  output logic                     hall_fault,
  output logic                     current_limited
);

  localparam int                MAG_W       = $clog2(PWM_PERIOD + 1);
  localparam int                DT_W        = $clog2(DEADTIME_CYCLES + 1);
  localparam logic [DUTY_W:0]   PERIOD_DUTY = (DUTY_W + 1)'(PWM_PERIOD);
  localparam logic [MAG_W-1:0]  PERIOD_MAG  = MAG_W'(PWM_PERIOD);
  localparam logic [DT_W-1:0]   DT_LOAD     = DT_W'(DEADTIME_CYCLES);

  logic [2:0]       code;
  logic             code_vld;
  logic [DUTY_W:0]  duty_ext, duty_abs;
  logic [CUR_W:0]   cur_ext, cur_abs, lim_ext, lim_abs;
  logic [MAG_W-1:0] mag_clamp, mag;
  logic             limited, pwm_on, bad_code, change, brake_d;
  logic [MAG_W-1:0] pwm_cnt_q, pwm_cnt_d;
  logic [2:0]       sector_q, sector_d;
  logic             dir_q, dir_d, hall_fault_q, hall_fault_d, cl_q, brake_q;
  gate_state_e      state_q, state_d;
  logic [DT_W-1:0]  dt_cnt_q, dt_cnt_d;
  logic [5:0]       pat, gate_q, gate_d;
  logic             in_dt_q;

  hall_filter #(.HALL_FILTER(HALL_FILTER)) u_hall_filter (
    .CLK      (CLK),
    .reset    (reset),
    .hall_raw (hall),
    .code     (code),
    .code_vld (code_vld)
  );

`ifdef BLDC_BRAKE_EN
  assign brake_d = brake;
`else
  assign brake_d = 1'b0;
`endif

  // Duty magnitude (widened so the most-negative duty saturates), clamp, fold-back and PWM compare.
  always_comb begin
    duty_ext  = {duty[DUTY_W-1], duty};
    duty_abs  = duty_ext[DUTY_W] ? (~duty_ext + {{DUTY_W{1'b0}}, 1'b1}) : duty_ext;
    cur_ext   = {current[CUR_W-1], current};
    cur_abs   = cur_ext[CUR_W] ? (~cur_ext + {{CUR_W{1'b0}}, 1'b1}) : cur_ext;
    lim_ext   = {current_limit[CUR_W-1], current_limit};
    lim_abs   = lim_ext[CUR_W] ? (~lim_ext + {{CUR_W{1'b0}}, 1'b1}) : lim_ext;
    mag_clamp = (duty_abs > PERIOD_DUTY) ? PERIOD_MAG : duty_abs[MAG_W-1:0];
    limited   = (cur_abs >= lim_abs);
    mag       = limited ? (mag_clamp >> FOLDBACK_SHIFT) : mag_clamp;
    pwm_cnt_d = (pwm_cnt_q == PERIOD_MAG - MAG_W'(1)) ? '0 : pwm_cnt_q + MAG_W'(1);
    pwm_on    = (pwm_cnt_q < mag);
  end

  // Sector, direction and sticky hall fault; a fault clears only while a valid code is held.
  always_comb begin
    sector_d     = code_vld ? hall_decode(code) : SEC_INVALID;
    bad_code     = code_vld && (hall_decode(code) == SEC_INVALID);
    dir_d        = ~duty[DUTY_W-1];
    hall_fault_d = hall_fault_q;
    if (bad_code) begin
      hall_fault_d = 1'b1;
    end else if (fault_clr && code_vld) begin
      hall_fault_d = 1'b0;
    end
    change = (sector_d != sector_q) || (dir_d != dir_q) || (brake_d != brake_q);
  end

  // Gate FSM next state and dead-time counter; gates are derived from the next state so they register together.
  always_comb begin
    state_d  = state_q;
    dt_cnt_d = dt_cnt_q;
    if (hall_fault_d) begin
      state_d = ST_FAULT;
    end else if (!enable) begin
      state_d = ST_OFF;
    end else begin
      case (state_q)
        ST_OFF: begin
          if (sector_d != SEC_INVALID) begin
            state_d  = ST_DEADTIME;
            dt_cnt_d = DT_LOAD;
          end
        end
        ST_DEADTIME: begin
          if (change) begin
            dt_cnt_d = DT_LOAD;
          end else if (dt_cnt_q <= DT_W'(1)) begin
            state_d = ST_DRIVE;
          end else begin
            dt_cnt_d = dt_cnt_q - DT_W'(1);
          end
        end
        ST_DRIVE: begin
          if (change) begin
            state_d  = ST_DEADTIME;
            dt_cnt_d = DT_LOAD;
          end
        end
        default: state_d = ST_OFF;
      endcase
    end
    pat    = brake_d ? 6'b000_111 : gate_pattern(sector_d, dir_d);
    gate_d = (state_d == ST_DRIVE) ? {pat[5:3] & {3{pwm_on}}, pat[2:0]} : 6'b000_000;
  end

  // Gate FSM state with its registered gate and dead-time outputs.
  always_ff @(posedge CLK) begin
    if (reset) begin
      state_q  <= ST_OFF;
      dt_cnt_q <= '0;
      gate_q   <= '0;
      in_dt_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      dt_cnt_q <= dt_cnt_d;
      gate_q   <= gate_d;
      in_dt_q  <= (state_d == ST_DEADTIME);
    end
  end

  // Datapath registers: PWM carrier, decoded sector, direction, status flags.
  always_ff @(posedge CLK) begin
    if (reset) begin
      pwm_cnt_q    <= '0;
      sector_q     <= SEC_INVALID;
      dir_q        <= 1'b1;
      hall_fault_q <= 1'b0;
      cl_q         <= 1'b0;
      brake_q      <= 1'b0;
    end else begin
      pwm_cnt_q    <= pwm_cnt_d;
      sector_q     <= sector_d;
      dir_q        <= dir_d;
      hall_fault_q <= hall_fault_d;
      cl_q         <= limited;
      brake_q      <= brake_d;
    end
  end

  assign {INHA, INHB, INHC, INLA, INLB, INLC} = gate_q;
  assign sector          = sector_q;
  assign dir             = dir_q;
  assign in_deadtime     = in_dt_q;
  assign hall_fault      = hall_fault_q;
  assign current_limited = cl_q;

endmodule
